decode_regfile_sb: RTL and testbench
====================================

// Module: decode_regfile_sb
// PURPOSE
// - Parametrised decode-stage integer register file: NUM_RD async read ports, NUM_WR sync write ports.
// - Adds what the single-port file lacks: full reset of every entry, hardwired zero register,
//   write-port priority and a per-register pending-write scoreboard for RAW stall generation.
// - Sits between fetch/decode and execute; writeback drives write ports, decode drives reads and issue.
// PARAMETERS
// - XLEN       32  data width of each register
// - NREGS      32  number of architectural registers (power of 2, >=2)
// - NUM_RD     2   read ports
// - NUM_WR     1   write ports (1..4); higher index = higher priority
// - ZERO_REG   1   1: register 0 reads 0, ignores writes, never busy
// - AW = $clog2(NREGS) (localparam)
// PORTS
// - clk        in   1            rising-edge clock
// - n_rst      in   1            async active-low reset
// - rd_addr    in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
// - rd_req     in   NUM_RD       port p operand is actually used this cycle
// - rd_data    out  NUM_RD*XLEN  read data, port p at [p*XLEN +: XLEN]
// - rd_busy    out  NUM_RD       scoreboard bit of rd_addr[p]
// - stall      out  1            OR over p of (rd_req[p] & rd_busy[p])
// - wr_en      in   NUM_WR       write strobe per port
// - wr_addr    in   NUM_WR*AW    write address per port
// - wr_data    in   NUM_WR*XLEN  write data per port
// - issue_en   in   1            an instruction with a destination leaves decode
// - issue_rd   in   AW           its destination register
// BEHAVIOUR
// - n_rst low (async, any time, incl. mid-write): all NREGS entries <= 0, all busy bits <= 0;
//   outputs follow combinationally: rd_data=0, rd_busy=0, stall=0. Writes/issues in that cycle lost.
// - Reads: combinational, zero latency, from registered state (write-before-read only with bypass).
// - Writes: on posedge, each wr_en[w] writes wr_data[w] to wr_addr[w].
//   Same address on several ports: highest-index enabled port wins; others dropped.
// - wr_addr >= NREGS impossible (AW exact); ZERO_REG=1 and addr 0: write discarded.
// - Scoreboard, one bit per register, updated on posedge:
//   - clear: any wr_en[w] to addr a clears busy[a];
//   - set: issue_en sets busy[issue_rd]; set beats clear on the same register same cycle
//     (new producer supersedes the retiring one);
//   - issue_rd = 0 with ZERO_REG=1: ignored; busy[0] constant 0.
//   - Set while already busy: stays busy (no counting; pipeline allows one in-flight writer/reg).
// - rd_busy/stall: combinational from current busy bits (and bypass, below); rd_req=0 masks stall.
// - stall does not gate issue_en internally; decode must suppress issue while stall=1.
// CONFIGURATION
// - Macro REGFILE_WR_BYPASS_EN:
//   - defined: for read port p, if any wr_en[w] targets rd_addr[p] this cycle, rd_data[p] =
//     wr_data of highest-priority such port and rd_busy[p] = 0 (the write is the retiring
//     producer); zero register still reads 0.
//   - undefined: rd_data/rd_busy reflect stored state only; new value visible the cycle after
//     the write; decode stalls one extra cycle on writeback-to-read hazards.
// TESTING
// - Reset: write x5=0xDEADBEEF, pulse n_rst low mid-cycle -> rd_data for x5 = 0 immediately, all rd_busy=0.
// - Zero reg: write x0=0x12345678 -> reading x0 returns 0; issue_en with issue_rd=0 -> rd_busy stays 0.
// - Priority (NUM_WR=2): port0 x7=0x11, port1 x7=0x22 same edge -> x7 reads 0x22.
// - Scoreboard: issue_rd=9, then rd_addr0=9, rd_req0=1 -> stall=1 until write x9=0xA5 retires;
//   next cycle stall=0, rd_data0=0xA5.
// - Set-beats-clear: same edge write x3 and issue_rd=3 -> busy[3]=1 afterwards, x3 holds new data.
// - Bypass: with REGFILE_WR_BYPASS_EN, write x4=0x55 while reading x4 -> same cycle rd_data=0x55,
//   rd_busy=0; without it, old value and busy=1 that cycle, 0x55 next cycle.

Source files
------------

// File: rtl/decode_regfile_sb_if.sv
// Decode/writeback bundle for decode_regfile_sb: read ports, write ports and issue/scoreboard signals.
// The master side belongs to decode and writeback, and the slave side belongs to the register file.
interface decode_regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD-1:0]      rd_req;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   stall;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   issue_en;
    logic [AW-1:0]          issue_rd;

    modport master (
        output rd_addr, rd_req, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rd_data, rd_busy, stall
    );

    modport slave (
        input  rd_addr, rd_req, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rd_data, rd_busy, stall
    );
endinterface

// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with asynchronous reads, prioritised writes and a RAW pending-write scoreboard.
// When REGFILE_WR_BYPASS_EN is defined, a write in the current cycle is forwarded to matching read ports.
module decode_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              n_rst,
    decode_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]        regs_q [NREGS];
    logic [XLEN-1:0]        regs_d [NREGS];
    logic [NREGS-1:0]       busy_q;
    logic [NREGS-1:0]       busy_d;
    logic [NUM_RD*XLEN-1:0] rdDataVec;
    logic [NUM_RD-1:0]      rdBusyVec;
    logic [AW-1:0]          readAddr;
    logic [AW-1:0]          writeAddr;

    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        writeAddr = '0;
        // Ports are visited in ascending order, so the highest-index port to the same address wins.
        for (int w = 0; w < NUM_WR; w++) begin
            writeAddr = bus.wr_addr[w*AW +: AW];
            if (bus.wr_en[w]) begin
                busy_d[writeAddr] = 1'b0;
                if (!(ZERO_REG != 0 && writeAddr == '0)) begin
                    regs_d[writeAddr] = bus.wr_data[w*XLEN +: XLEN];
                end
            end
        end
        if (bus.issue_en) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdDataVec = '0;
        rdBusyVec = '0;
        readAddr  = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            readAddr                    = bus.rd_addr[p*AW +: AW];
            rdDataVec[p*XLEN +: XLEN]   = regs_q[readAddr];
            rdBusyVec[p]                = busy_q[readAddr];
`ifdef REGFILE_WR_BYPASS_EN
            // The forwarded write is the retiring producer, so it also clears the busy bit.
            for (int w = 0; w < NUM_WR; w++) begin
                if (n_rst && bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == readAddr) begin
                    rdDataVec[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
                    rdBusyVec[p]              = 1'b0;
                end
            end
`endif
            if (ZERO_REG != 0 && readAddr == '0) begin
                rdDataVec[p*XLEN +: XLEN] = '0;
                rdBusyVec[p]              = 1'b0;
            end
        end
    end

    assign bus.rd_data = rdDataVec;
    assign bus.rd_busy = rdBusyVec;
    assign bus.stall   = |(bus.rd_req & rdBusyVec);
endmodule

// File: tb/tb_decode_regfile_sb.sv
// Directed testbench for decode_regfile_sb with two read ports and two write ports.
// Expectations for same-cycle reads depend on whether REGFILE_WR_BYPASS_EN is defined.
module tb_decode_regfile_sb;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = 5;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    decode_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    decode_regfile_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.rd_addr  = '0;
        bus.rd_req   = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
    endtask

    task automatic setRead(input int p, input logic [AW-1:0] a, input logic req);
        bus.rd_addr[p*AW +: AW] = a;
        bus.rd_req[p]           = req;
    endtask

    task automatic setWrite(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wr_en[w]              = 1'b1;
        bus.wr_addr[w*AW +: AW]   = a;
        bus.wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        bus.issue_en = 1'b1;
        bus.issue_rd = a;
    endtask

    // One clock edge; single-cycle strobes drop right after it and reads settle before checking.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_en    = '0;
        bus.issue_en = 1'b0;
        #1;
    endtask

    function automatic logic [XLEN-1:0] rdData(input int p);
        return bus.rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        clearInputs();
        #1 n_rst = 1'b0;
        #1;
        total++;
        if (bus.rd_data !== '0) begin
            bad++; $display("[TB] FAIL reset_rd_data got=%h want=0", bus.rd_data);
        end
        total++;
        if (bus.rd_busy !== 2'b00 || bus.stall !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy got busy=%b stall=%b want 00/0", bus.rd_busy, bus.stall);
        end
        @(negedge clk) n_rst = 1'b1;
        setWrite(0, 5'd5, 32'hDEADBEEF);
        issue(5'd6);
        setRead(0, 5'd5, 1'b1);
        setRead(1, 5'd6, 1'b1);
        tick();
        total++;
        if (rdData(0) !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL x5_written got=%h want=deadbeef", rdData(0));
        end
        total++;
        if (bus.rd_busy !== 2'b10 || bus.stall !== 1'b1) begin
            bad++; $display("[TB] FAIL x6_busy got busy=%b stall=%b want 10/1", bus.rd_busy, bus.stall);
        end
        #2 n_rst = 1'b0;
        #1;
        total++;
        if (rdData(0) !== 32'h0 || bus.rd_busy !== 2'b00 || bus.stall !== 1'b0) begin
            bad++; $display("[TB] FAIL midcycle_reset got data=%h busy=%b stall=%b want 0/00/0",
                            rdData(0), bus.rd_busy, bus.stall);
        end
        setWrite(0, 5'd5, 32'hCAFEF00D);
        issue(5'd5);
        @(posedge clk);
        #1;
        bus.wr_en    = '0;
        bus.issue_en = 1'b0;
        @(negedge clk) n_rst = 1'b1;
        #1;
        total++;
        if (rdData(0) !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
            bad++; $display("[TB] FAIL write_during_reset got data=%h busy=%b want 0/0", rdData(0), bus.rd_busy[0]);
        end
    endtask

    task automatic test_zero_reg();
        clearInputs();
        setWrite(0, 5'd0, 32'h12345678);
        setRead(0, 5'd0, 1'b1);
        tick();
        total++;
        if (rdData(0) !== 32'h0) begin
            bad++; $display("[TB] FAIL x0_write got=%h want=0", rdData(0));
        end
        issue(5'd0);
        tick();
        total++;
        if (bus.rd_busy[0] !== 1'b0 || bus.stall !== 1'b0) begin
            bad++; $display("[TB] FAIL x0_issue got busy=%b stall=%b want 0/0", bus.rd_busy[0], bus.stall);
        end
    endtask

    task automatic test_priority();
        clearInputs();
        setWrite(0, 5'd7, 32'h11);
        setWrite(1, 5'd7, 32'h22);
        tick();
        setRead(0, 5'd7, 1'b1);
        #1;
        total++;
        if (rdData(0) !== 32'h22) begin
            bad++; $display("[TB] FAIL wr_priority got=%h want=22", rdData(0));
        end
        setWrite(0, 5'd8, 32'h33);
        setWrite(1, 5'd10, 32'h44);
        tick();
        setRead(0, 5'd8, 1'b0);
        setRead(1, 5'd10, 1'b0);
        #1;
        total++;
        if (rdData(0) !== 32'h33 || rdData(1) !== 32'h44) begin
            bad++; $display("[TB] FAIL dual_write got=%h,%h want=33,44", rdData(0), rdData(1));
        end
    endtask

    task automatic test_scoreboard();
        clearInputs();
        issue(5'd9);
        tick();
        setRead(0, 5'd9, 1'b1);
        #1;
        total++;
        if (bus.stall !== 1'b1 || bus.rd_busy[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL raw_stall got stall=%b busy=%b want 1/1", bus.stall, bus.rd_busy[0]);
        end
        bus.rd_req[0] = 1'b0;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++; $display("[TB] FAIL req_mask got stall=%b want 0", bus.stall);
        end
        bus.rd_req[0] = 1'b1;
        tick();
        tick();
        total++;
        if (bus.stall !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_held got stall=%b want 1", bus.stall);
        end
        setWrite(0, 5'd9, 32'hA5);
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        total++;
        if (bus.stall !== 1'b0 || rdData(0) !== 32'hA5) begin
            bad++; $display("[TB] FAIL retire_cycle got stall=%b data=%h want 0/a5", bus.stall, rdData(0));
        end
`else
        total++;
        if (bus.stall !== 1'b1 || rdData(0) !== 32'h0) begin
            bad++; $display("[TB] FAIL retire_cycle got stall=%b data=%h want 1/0", bus.stall, rdData(0));
        end
`endif
        tick();
        total++;
        if (bus.stall !== 1'b0 || rdData(0) !== 32'hA5) begin
            bad++; $display("[TB] FAIL after_retire got stall=%b data=%h want 0/a5", bus.stall, rdData(0));
        end
    endtask

    task automatic test_set_beats_clear();
        clearInputs();
        issue(5'd3);
        tick();
        setWrite(0, 5'd3, 32'h77);
        issue(5'd3);
        tick();
        setRead(0, 5'd3, 1'b1);
        #1;
        total++;
        if (bus.rd_busy[0] !== 1'b1 || rdData(0) !== 32'h77) begin
            bad++; $display("[TB] FAIL set_beats_clear got busy=%b data=%h want 1/77", bus.rd_busy[0], rdData(0));
        end
        setWrite(1, 5'd3, 32'h78);
        tick();
        total++;
        if (bus.rd_busy[0] !== 1'b0 || rdData(0) !== 32'h78) begin
            bad++; $display("[TB] FAIL clear_only got busy=%b data=%h want 0/78", bus.rd_busy[0], rdData(0));
        end
    endtask

    task automatic test_bypass();
        clearInputs();
        setWrite(0, 5'd4, 32'h11);
        tick();
        issue(5'd4);
        tick();
        setRead(1, 5'd4, 1'b1);
        setWrite(1, 5'd4, 32'h55);
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        total++;
        if (rdData(1) !== 32'h55 || bus.rd_busy[1] !== 1'b0) begin
            bad++; $display("[TB] FAIL bypass_same_cycle got data=%h busy=%b want 55/0", rdData(1), bus.rd_busy[1]);
        end
`else
        total++;
        if (rdData(1) !== 32'h11 || bus.rd_busy[1] !== 1'b1) begin
            bad++; $display("[TB] FAIL bypass_same_cycle got data=%h busy=%b want 11/1", rdData(1), bus.rd_busy[1]);
        end
`endif
        tick();
        total++;
        if (rdData(1) !== 32'h55 || bus.rd_busy[1] !== 1'b0) begin
            bad++; $display("[TB] FAIL bypass_next_cycle got data=%h busy=%b want 55/0", rdData(1), bus.rd_busy[1]);
        end
        setWrite(0, 5'd4, 32'h66);
        setWrite(1, 5'd4, 32'h99);
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        total++;
        if (rdData(1) !== 32'h99) begin
            bad++; $display("[TB] FAIL bypass_priority got=%h want=99", rdData(1));
        end
`else
        total++;
        if (rdData(1) !== 32'h55) begin
            bad++; $display("[TB] FAIL bypass_priority got=%h want=55", rdData(1));
        end
`endif
        tick();
        total++;
        if (rdData(1) !== 32'h99) begin
            bad++; $display("[TB] FAIL priority_stored got=%h want=99", rdData(1));
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals [4];
        vals[0] = 32'hA0A0_0001;
        vals[1] = 32'hB1B1_0002;
        vals[2] = 32'hC2C2_0003;
        vals[3] = 32'hD3D3_0004;
        clearInputs();
        for (int i = 0; i < 4; i++) begin
            setWrite(i % 2, AW'(12 + i), vals[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            setRead(0, AW'(12 + i), 1'b1);
            #1;
            total++;
            if (rdData(0) !== vals[i] || bus.stall !== 1'b0) begin
                bad++; $display("[TB] FAIL back_to_back x%0d got data=%h stall=%b want %h/0",
                                12 + i, rdData(0), bus.stall, vals[i]);
            end
        end
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_zero_reg();
        test_priority();
        test_scoreboard();
        test_set_beats_clear();
        test_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
